// File: rtl/rkey_reverse_buffer.sv
// Round-key reverse buffer: captures a forward key schedule and replays it last-to-first, wrapping per block.
// Build option RK_INVMIX_EN: middle keys are presented through InvMixColumns (equivalent inverse cipher).
module rkey_reverse_buffer #(
  parameter int MAX_RK = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [0:127]                   in_rkey,
  input  logic                           in_rkey_vld,
  input  logic                           in_rkey_last,
  output logic                           load_rdy,
  input  logic                           rekey,
  output logic [0:127]                   out_rkey,
  output logic                           out_rkey_vld,
  input  logic                           out_rkey_rdy,
  output logic                           out_rkey_first,
  output logic                           out_rkey_last,
  output logic [$clog2(MAX_RK+1)-1:0]    nrk,
  output logic                           ovf
);
  localparam int NW = $clog2(MAX_RK+1);
  localparam logic [NW-1:0] MAXV = NW'(MAX_RK);
  localparam logic [NW-1:0] ONE  = NW'(1);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t          state;
  logic [NW-1:0]   wptr, rptr, nrk_q;
  logic            ovf_q;
  logic [127:0]    mem [MAX_RK];
  logic [127:0]    rd;
  logic            wen, is_first, is_last;

  // wptr is zero in EMPTY, so it addresses both the first and later writes
  assign wen = !rst && !rekey && in_rkey_vld && (state != READY) && (wptr < MAXV);

  always_ff @(posedge clk) begin
    if (wen) mem[wptr] <= in_rkey;
  end

  always_ff @(posedge clk) begin
    if (rst || rekey) begin
      state <= EMPTY;
      wptr  <= '0;
      rptr  <= '0;
      nrk_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (in_rkey_vld) begin
          wptr <= ONE;
          if (in_rkey_last) begin
            state <= READY;
            nrk_q <= ONE;
            rptr  <= '0;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: if (in_rkey_vld) begin
          if (wptr < MAXV) wptr <= wptr + ONE;
          else             ovf_q <= 1'b1;
          if (in_rkey_last) begin
            state <= READY;
            nrk_q <= (wptr < MAXV) ? wptr + ONE : MAXV;
            rptr  <= (wptr < MAXV) ? wptr : MAXV - ONE;
          end
        end
        READY: if (out_rkey_rdy) begin
          rptr <= (rptr == '0) ? nrk_q - ONE : rptr - ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign load_rdy     = (state == EMPTY);
  assign out_rkey_vld = (state == READY);
  assign nrk          = nrk_q;
  assign ovf          = ovf_q;

  assign rd       = mem[rptr];
  assign is_first = out_rkey_vld && (rptr == nrk_q - ONE);
  assign is_last  = out_rkey_vld && (rptr == '0);
  assign out_rkey_first = is_first;
  assign out_rkey_last  = is_last;

`ifdef RK_INVMIX_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One 32-bit column, byte 0 in the msbs
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = m14[i] ^ m11[(i+1)%4] ^ m13[(i+2)%4] ^ m9[(i+3)%4];
    return r;
  endfunction

  logic [127:0] mixed;
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = inv_col(rd[127-32*c -: 32]);
  end

  assign out_rkey = (out_rkey_vld && !is_first && !is_last) ? mixed : rd;
`else
  assign out_rkey = rd;
`endif

endmodule
